// File: rtl/instr_mem_loader.sv
// Byte-stream to instruction-memory loader: packs 4 bytes big-endian per word and writes word by word.
// Optional LOADER_PAD_FILL_EN pads the rest of memory with HALT_WORD after the halt word.
module instr_mem_loader #(
    parameter int          SIZE_IM   = 128,
    parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [7:0]  word_count
);

`ifdef LOADER_PAD_FILL_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, FILL, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    localparam logic [31:0] LAST_IDX = 32'(SIZE_IM - 1);

    state_t      state;
    logic [1:0]  byte_idx;
    logic [31:0] word_idx;
    logic [23:0] shift;
    logic        full_stop;  // load ended because memory filled, so late bytes are overflow

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= 32'd0;
            wr_data    <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= 8'd0;
            byte_idx   <= 2'd0;
            word_idx   <= 32'd0;
            shift      <= 24'd0;
            full_stop  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RECV;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        overflow   <= 1'b0;
                        full_stop  <= 1'b0;
                        word_count <= 8'd0;
                        byte_idx   <= 2'd0;
                        word_idx   <= 32'd0;
                    end else if (state == DONE && byte_valid && full_stop) begin
                        overflow <= 1'b1;
                    end
                end

                RECV: begin
                    if (byte_valid) begin
                        shift    <= {shift[15:0], byte_in};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            wr_en      <= 1'b1;
                            wr_addr    <= word_idx << 2;
                            wr_data    <= {shift, byte_in};
                        end
                    end
                end

                WRITE: begin
                    word_count <= word_count + 8'd1;
                    wr_en      <= 1'b0;
                    if (wr_data == HALT_WORD) begin
`ifdef LOADER_PAD_FILL_EN
                        if (word_idx != LAST_IDX) begin
                            state    <= FILL;
                            wr_en    <= 1'b1;
                            wr_addr  <= (word_idx + 32'd1) << 2;
                            word_idx <= word_idx + 32'd1;
                        end else begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            byte_ready <= 1'b1;
                        end
`else
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        byte_ready <= 1'b1;
`endif
                    end else if (word_idx == LAST_IDX) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        byte_ready <= 1'b1;
                        full_stop  <= 1'b1;
                    end else begin
                        state      <= RECV;
                        byte_ready <= 1'b1;
                        word_idx   <= word_idx + 32'd1;
                        byte_idx   <= 2'd0;
                    end
                end

`ifdef LOADER_PAD_FILL_EN
                // wr_data still holds HALT_WORD from the halt write
                FILL: begin
                    if (word_idx == LAST_IDX) begin
                        state      <= DONE;
                        wr_en      <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        byte_ready <= 1'b1;
                    end else begin
                        word_idx <= word_idx + 32'd1;
                        wr_addr  <= (word_idx + 32'd1) << 2;
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a 128-word instance and a 4-word instance share the byte stream.
module tb_instr_mem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic [7:0] byte_in = 8'd0;
    logic       byte_valid = 1'b0;

    logic        byte_ready_a, wr_en_a, busy_a, done_a, overflow_a;
    logic [31:0] wr_addr_a, wr_data_a;
    logic [7:0]  word_count_a;
    logic        byte_ready_b, wr_en_b, busy_b, done_b, overflow_b;
    logic [31:0] wr_addr_b, wr_data_b;
    logic [7:0]  word_count_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];

    instr_mem_loader dut_a (
        .clk(clk), .rst(rst), .start(start_a), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .done(done_a), .overflow(overflow_a), .word_count(word_count_a)
    );

    instr_mem_loader #(.SIZE_IM(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .done(done_b), .overflow(overflow_b), .word_count(word_count_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en_a) begin
            qa_addr.push_back(wr_addr_a);
            qa_data.push_back(wr_data_a);
        end
        if (wr_en_b) begin
            qb_addr.push_back(wr_addr_b);
            qb_data.push_back(wr_data_b);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
    endtask

    // Entered and left on a falling edge; the handshake falls on the rising edge in between.
    task automatic push(input bit sel, input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        byte_in = b;
        byte_valid = 1'b1;
        t = 0;
        while (!(sel ? byte_ready_b : byte_ready_a) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!(sel ? byte_ready_b : byte_ready_a)) begin
            checks++; failures++;
            $display("FAIL push_timeout: byte_ready stayed 0 for byte %h, required 1", b);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({byte_ready_a, wr_en_a, busy_a, done_a, overflow_a, wr_addr_a, wr_data_a, word_count_a} !== '0) begin
            failures++;
            $display("FAIL reset_state: outputs %h, required 0",
                     {byte_ready_a, wr_en_a, busy_a, done_a, overflow_a, wr_addr_a, wr_data_a, word_count_a});
        end
        pulse_start(0);
        checks++;
        if ({busy_a, byte_ready_a} !== 2'b11) begin
            failures++;
            $display("FAIL start_recv: busy,ready=%b required 11", {busy_a, byte_ready_a});
        end
        push(0, 8'h12, 0);
        push(0, 8'h34, 0);
        rst = 1'b1;
        #1;
        checks++;
        if ({byte_ready_a, wr_en_a, busy_a, done_a, overflow_a, wr_addr_a, wr_data_a, word_count_a} !== '0) begin
            failures++;
            $display("FAIL async_reset: outputs %h, required 0",
                     {byte_ready_a, wr_en_a, busy_a, done_a, overflow_a, wr_addr_a, wr_data_a, word_count_a});
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (qa_addr.size() != 0) begin
            failures++;
            $display("FAIL reset_no_write: writes=%0d required 0", qa_addr.size());
        end
        pulse_start(0);
        push(0, 8'hAA, 0);
        push(0, 8'hBB, 0);
        push(0, 8'hCC, 0);
        push(0, 8'hDD, 0);
        checks++;
        if ({wr_en_a, wr_addr_a, wr_data_a} !== {1'b1, 32'd0, 32'hAABBCCDD}) begin
            failures++;
            $display("FAIL reload_word0: en=%b addr=%h data=%h required 1 00000000 aabbccdd",
                     wr_en_a, wr_addr_a, wr_data_a);
        end
    endtask

    task automatic test_two_words();
        do_reset();
        pulse_start(0);
        push(0, 8'h12, 0);
        push(0, 8'h34, 0);
        push(0, 8'h56, 0);
        checks++;
        if (wr_en_a !== 1'b0) begin
            failures++;
            $display("FAIL early_write: wr_en=%b after 3 bytes, required 0", wr_en_a);
        end
        push(0, 8'h78, 0);
        checks++;
        if ({wr_en_a, wr_addr_a, wr_data_a} !== {1'b1, 32'd0, 32'h12345678}) begin
            failures++;
            $display("FAIL word0: en=%b addr=%h data=%h required 1 00000000 12345678",
                     wr_en_a, wr_addr_a, wr_data_a);
        end
        push(0, 8'hAB, 0);
        push(0, 8'hCD, 0);
        push(0, 8'hEF, 0);
        push(0, 8'h01, 0);
        checks++;
        if ({wr_en_a, wr_addr_a, wr_data_a} !== {1'b1, 32'd4, 32'hABCDEF01}) begin
            failures++;
            $display("FAIL word1: en=%b addr=%h data=%h required 1 00000004 abcdef01",
                     wr_en_a, wr_addr_a, wr_data_a);
        end
        @(negedge clk);
        checks++;
        if ({wr_en_a, busy_a, done_a, word_count_a} !== {1'b0, 1'b1, 1'b0, 8'd2}) begin
            failures++;
            $display("FAIL after_two: en=%b busy=%b done=%b count=%0d required 0 1 0 2",
                     wr_en_a, busy_a, done_a, word_count_a);
        end
    endtask

    task automatic test_halt();
        int t;
        int bad;
        int exp_n;
        do_reset();
        pulse_start(0);
        push(0, 8'h00, 0);
        push(0, 8'h00, 0);
        push(0, 8'h00, 0);
        push(0, 8'h20, 0);
        push(0, 8'hFC, 0);
        push(0, 8'h00, 0);
        push(0, 8'h00, 0);
        push(0, 8'h00, 0);
        t = 0;
        while (!done_a && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if ({done_a, busy_a, word_count_a} !== {1'b1, 1'b0, 8'd2}) begin
            failures++;
            $display("FAIL halt_done: done=%b busy=%b count=%0d required 1 0 2", done_a, busy_a, word_count_a);
        end
`ifdef LOADER_PAD_FILL_EN
        exp_n = 128;
`else
        exp_n = 2;
`endif
        checks++;
        if (qa_addr.size() != exp_n) begin
            failures++;
            $display("FAIL halt_write_count: writes=%0d required %0d", qa_addr.size(), exp_n);
        end
        bad = 0;
        if (qa_addr.size() >= 2) begin
            if (qa_addr[0] !== 32'd0 || qa_data[0] !== 32'h00000020) bad++;
            if (qa_addr[1] !== 32'd4 || qa_data[1] !== 32'hFC000000) bad++;
            for (int i = 2; i < qa_addr.size(); i++)
                if (qa_addr[i] !== 32'(i * 4) || qa_data[i] !== 32'hFC000000) bad++;
        end else begin
            bad = 1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL halt_writes: %0d bad entries, required 0", bad);
        end
        push(0, 8'h55, 0);
        @(negedge clk);
        checks++;
        if ({overflow_a, done_a, byte_ready_a} !== 3'b011 || qa_addr.size() != exp_n) begin
            failures++;
            $display("FAIL after_halt_byte: ovf=%b done=%b ready=%b writes=%0d required 0 1 1 %0d",
                     overflow_a, done_a, byte_ready_a, qa_addr.size(), exp_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [8];
        int         gaps  [8];
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01};
        gaps  = '{2, 0, 1, 3, 0, 4, 1, 2};
        do_reset();
        byte_in = 8'h99;
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if ({busy_a, byte_ready_a, wr_en_a} !== 3'b000) begin
            failures++;
            $display("FAIL idle_ignore: busy,ready,en=%b required 000", {busy_a, byte_ready_a, wr_en_a});
        end
        pulse_start(0);
        for (int i = 0; i < 8; i++) begin
            push(0, bytes[i], gaps[i]);
            if (i == 1 || i == 5) pulse_start(0);
        end
        @(negedge clk);
        checks++;
        if (qa_addr.size() != 2) begin
            failures++;
            $display("FAIL gapped_count: writes=%0d required 2", qa_addr.size());
        end else begin
            checks++;
            if ({qa_addr[0], qa_data[0], qa_addr[1], qa_data[1]} !==
                {32'd0, 32'h12345678, 32'd4, 32'hABCDEF01}) begin
                failures++;
                $display("FAIL gapped_data: %h %h %h %h required 0 12345678 4 abcdef01",
                         qa_addr[0], qa_data[0], qa_addr[1], qa_data[1]);
            end
        end
        checks++;
        if ({word_count_a, busy_a} !== {8'd2, 1'b1}) begin
            failures++;
            $display("FAIL gapped_state: count=%0d busy=%b required 2 1", word_count_a, busy_a);
        end
    endtask

    task automatic test_overflow();
        int bad;
        do_reset();
        pulse_start(1);
        for (int i = 0; i < 16; i++) push(1, 8'(i + 1), 0);
        @(negedge clk);
        checks++;
        if ({done_b, busy_b, overflow_b, byte_ready_b, word_count_b} !== {4'b1001, 8'd4}) begin
            failures++;
            $display("FAIL full_done: done=%b busy=%b ovf=%b ready=%b count=%0d required 1 0 0 1 4",
                     done_b, busy_b, overflow_b, byte_ready_b, word_count_b);
        end
        push(1, 8'h11, 0);
        checks++;
        if (overflow_b !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: ovf=%b required 1", overflow_b);
        end
        for (int i = 0; i < 3; i++) push(1, 8'h22, 0);
        bad = 0;
        if (qb_addr.size() != 4) bad = 99;
        else
            for (int i = 0; i < 4; i++)
                if (qb_addr[i] !== 32'(i * 4) ||
                    qb_data[i] !== {8'(4*i+1), 8'(4*i+2), 8'(4*i+3), 8'(4*i+4)}) bad++;
        checks++;
        if (bad != 0 || overflow_b !== 1'b1) begin
            failures++;
            $display("FAIL full_writes: bad=%0d writes=%0d ovf=%b required 0 4 1", bad, qb_addr.size(), overflow_b);
        end
        pulse_start(1);
        checks++;
        if ({overflow_b, done_b, busy_b, word_count_b} !== {3'b001, 8'd0}) begin
            failures++;
            $display("FAIL restart_clear: ovf=%b done=%b busy=%b count=%0d required 0 0 1 0",
                     overflow_b, done_b, busy_b, word_count_b);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_halt();
        test_back_to_back();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
